adc_multichannel_sampler: RTL and testbench

//  Parametrised scan controller for the modular ADC command/response Avalon-ST pair.

---
 rtl/adc_sampler_pkg.sv | 20 ++
 rtl/adc_tick_gen.sv | 25 ++
 rtl/adc_multichannel_sampler.sv | 184 ++++++++++++++++++
 tb/tb_adc_multichannel_sampler.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sampler_pkg.sv
// Shared types and helpers for the multichannel ADC scan controller.
package adc_sampler_pkg;

  localparam int unsigned CH_W   = 5;
  localparam int unsigned MAX_CH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    EMIT
  } state_t;

  // Entry idx of a channel map that has been zero-extended to MAX_CH entries.
  function automatic logic [CH_W-1:0] ch_of(input logic [MAX_CH*CH_W-1:0] map,
                                            input logic [2:0]             idx);
    return map[idx*CH_W +: CH_W];
  endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Frame tick generator: one-cycle pulse every SAMPLE_DIV clocks while enabled.
module adc_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 1000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(SAMPLE_DIV - 1));
  assign o_tick = i_en & w_wrap;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              r_cnt <= '0;
    else if (!i_en || w_wrap)  r_cnt <= '0;
    else                       r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/adc_multichannel_sampler.sv
// Scan controller: per frame tick, issues 2^AVG_LOG2 conversions per mapped
// channel on the ADC command stream, averages responses, emits a framed stream.
module adc_multichannel_sampler
  import adc_sampler_pkg::*;
#(
  parameter int unsigned                 NUM_CH       = 4,
  parameter logic [NUM_CH*CH_W-1:0]      CH_MAP       = {5'd4, 5'd3, 5'd2, 5'd1},
  parameter int unsigned                 DATA_W       = 12,
  parameter int unsigned                 AVG_LOG2     = 2,
  parameter int unsigned                 SAMPLE_DIV   = 1000,
  parameter int unsigned                 RESP_TIMEOUT = 255
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  output logic              cmd_valid,
  output logic [CH_W-1:0]   cmd_channel,
  output logic              cmd_sop,
  output logic              cmd_eop,
  input  logic              cmd_ready,
  input  logic              rsp_valid,
  input  logic [CH_W-1:0]   rsp_channel,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CH_W-1:0]   out_channel,
  output logic              out_sop,
  output logic              out_eop,
  output logic              busy,
  output logic              err_overrun,
  output logic              err_missed_tick,
  output logic              err_resp,
  input  logic              err_clear
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNV_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
  localparam int unsigned TMO_W = $clog2(RESP_TIMEOUT + 1);

  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [CNV_W-1:0]         LAST_CNV = CNV_W'((1 << AVG_LOG2) - 1);
  localparam logic [TMO_W-1:0]         TMO_LAST = TMO_W'(RESP_TIMEOUT - 1);
  localparam logic [MAX_CH*CH_W-1:0]   MAP_EXT  = (MAX_CH*CH_W)'(CH_MAP);

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ch_idx, w_idx_nxt;
  logic [CNV_W-1:0]   r_conv, w_conv_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;

  logic               w_tick;
  logic [CH_W-1:0]    w_cur_ch;
  logic               w_rsp_hit;
  logic [DATA_W-1:0]  w_result;
  logic               w_load, w_overrun, w_resp_err, w_next_ch, w_missed;

  adc_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_en    (enable),
    .o_tick  (w_tick)
  );

  assign w_cur_ch    = ch_of(MAP_EXT, 3'(r_ch_idx));
  assign w_rsp_hit   = rsp_valid && (rsp_channel == w_cur_ch);
  assign w_result    = DATA_W'(r_acc >> AVG_LOG2);
  assign w_missed    = w_tick && (r_state != IDLE);

  assign cmd_valid   = (r_state == ISSUE);
  assign cmd_channel = cmd_valid ? w_cur_ch : '0;
  assign cmd_sop     = cmd_valid;
  assign cmd_eop     = cmd_valid;
  assign busy        = (r_state != IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_ch_idx;
    w_conv_nxt  = r_conv;
    w_acc_nxt   = r_acc;
    w_tmo_nxt   = r_tmo;
    w_load      = 1'b0;
    w_overrun   = 1'b0;
    w_resp_err  = 1'b0;
    w_next_ch   = 1'b0;
    case (r_state)
      IDLE: if (w_tick) begin
        w_state_nxt = ISSUE;
        w_idx_nxt   = '0;
        w_conv_nxt  = '0;
        w_acc_nxt   = '0;
      end
      ISSUE: if (cmd_ready) begin
        w_state_nxt = WAIT_RSP;
        w_tmo_nxt   = '0;
      end
      WAIT_RSP: begin
        if (w_rsp_hit) begin
          w_acc_nxt = r_acc + ACC_W'(rsp_data);
          if (r_conv == LAST_CNV) begin
            w_state_nxt = EMIT;
          end else begin
            w_conv_nxt  = r_conv + 1'b1;
            w_state_nxt = ISSUE;
          end
        end else begin
          // A mismatched response flags an error but does not restart the timeout.
          w_resp_err = rsp_valid;
          if (r_tmo == TMO_LAST) begin
            w_resp_err = 1'b1;
            w_next_ch  = 1'b1;
          end else begin
            w_tmo_nxt = r_tmo + 1'b1;
          end
        end
      end
      EMIT: begin
        if (!out_valid || out_ready) w_load    = 1'b1;
        else                         w_overrun = 1'b1;
        w_next_ch = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
    // Shared by EMIT and the timeout abandon path.
    if (w_next_ch) begin
      if (r_ch_idx == LAST_IDX) begin
        w_state_nxt = IDLE;
      end else begin
        w_idx_nxt   = r_ch_idx + 1'b1;
        w_conv_nxt  = '0;
        w_acc_nxt   = '0;
        w_state_nxt = ISSUE;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state  <= IDLE;
      r_ch_idx <= '0;
      r_conv   <= '0;
      r_acc    <= '0;
      r_tmo    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_ch_idx <= w_idx_nxt;
      r_conv   <= w_conv_nxt;
      r_acc    <= w_acc_nxt;
      r_tmo    <= w_tmo_nxt;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
    end else if (w_load) begin
      out_valid   <= 1'b1;
      out_data    <= w_result;
      out_channel <= w_cur_ch;
      out_sop     <= (r_ch_idx == '0);
      out_eop     <= (r_ch_idx == LAST_IDX);
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      err_overrun     <= 1'b0;
      err_missed_tick <= 1'b0;
      err_resp        <= 1'b0;
    end else begin
      err_overrun     <= w_overrun  | (err_overrun     & ~err_clear);
      err_missed_tick <= w_missed   | (err_missed_tick & ~err_clear);
      err_resp        <= w_resp_err | (err_resp        & ~err_clear);
    end
  end

endmodule

// File: tb/tb_adc_multichannel_sampler.sv
// Directed bench: ADC response model, scoreboard of expected output beats.
module tb_adc_multichannel_sampler;

  localparam int SDIV = 64;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        enable;
  logic        cmd_valid, cmd_sop, cmd_eop, cmd_ready;
  logic [4:0]  cmd_channel;
  logic        rsp_valid;
  logic [4:0]  rsp_channel;
  logic [11:0] rsp_data;
  logic        out_valid, out_ready, out_sop, out_eop;
  logic [11:0] out_data;
  logic [4:0]  out_channel;
  logic        busy, err_overrun, err_missed_tick, err_resp, err_clear;

  always #5 clk_clk = ~clk_clk;

  adc_multichannel_sampler #(
    .NUM_CH       (4),
    .CH_MAP       ({5'd4, 5'd3, 5'd2, 5'd1}),
    .DATA_W       (12),
    .AVG_LOG2     (2),
    .SAMPLE_DIV   (SDIV),
    .RESP_TIMEOUT (255)
  ) dut (
    .clk_clk         (clk_clk),
    .reset_reset_n   (reset_reset_n),
    .enable          (enable),
    .cmd_valid       (cmd_valid),
    .cmd_channel     (cmd_channel),
    .cmd_sop         (cmd_sop),
    .cmd_eop         (cmd_eop),
    .cmd_ready       (cmd_ready),
    .rsp_valid       (rsp_valid),
    .rsp_channel     (rsp_channel),
    .rsp_data        (rsp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_channel     (out_channel),
    .out_sop         (out_sop),
    .out_eop         (out_eop),
    .busy            (busy),
    .err_overrun     (err_overrun),
    .err_missed_tick (err_missed_tick),
    .err_resp        (err_resp),
    .err_clear       (err_clear)
  );

  typedef struct packed {
    logic [11:0] data;
    logic [4:0]  ch;
    logic        sop;
    logic        eop;
  } beat_t;

  beat_t sb[$];
  beat_t mon_got, mon_exp;
  int    n_tests = 0;
  int    n_fail  = 0;

  int         lat     = 1;
  int         off     = 0;
  bit         bad_ch2 = 1'b0;
  int         kcnt[32];
  int         m_pend  = 0;
  logic [4:0] m_pch   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Conversion k of channel ch returns 100 + k + off*ch; the average of four.
  function automatic logic [11:0] exp_avg(input int ch);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += 100 + k + off * ch;
    return 12'(s / 4);
  endfunction

  task automatic push_beat(input int ch, input bit sop, input bit eop);
    beat_t b;
    b.data = exp_avg(ch);
    b.ch   = 5'(ch);
    b.sop  = sop;
    b.eop  = eop;
    sb.push_back(b);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  // sel: 0 busy high, 1 busy low, 2 cmd_valid, 3 cmd_valid on channel 2
  task automatic wait_cond(input int sel, input int lim, input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < lim && !ok; n++) begin
      cyc(1);
      case (sel)
        0:       ok = busy;
        1:       ok = !busy;
        2:       ok = cmd_valid;
        default: ok = cmd_valid && (cmd_channel == 5'd2);
      endcase
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic clear_model();
    foreach (kcnt[i]) kcnt[i] = 0;
  endtask

  task automatic pulse_err_clear();
    err_clear = 1'b1;
    cyc(1);
    err_clear = 1'b0;
  endtask

  // ADC model: answers an accepted command lat cycles later.
  initial begin
    rsp_valid   = 1'b0;
    rsp_channel = '0;
    rsp_data    = '0;
    forever begin
      @(negedge clk_clk);
      rsp_valid = 1'b0;
      if (m_pend > 0) begin
        m_pend--;
        if (m_pend == 0) begin
          if (bad_ch2 && m_pch == 5'd2) begin
            rsp_channel = 5'd9;
            rsp_data    = 12'd4000;
          end else begin
            rsp_channel = m_pch;
            rsp_data    = 12'(100 + (kcnt[m_pch] % 4) + off * int'(m_pch));
            kcnt[m_pch]++;
          end
          rsp_valid = 1'b1;
        end
      end
      if (reset_reset_n && cmd_valid && cmd_ready) begin
        m_pch  = cmd_channel;
        m_pend = lat;
      end
    end
  end

  // Output monitor: every accepted beat is compared with the scoreboard head.
  initial begin
    forever begin
      @(negedge clk_clk);
      if (reset_reset_n && out_valid && out_ready) begin
        mon_got = '{out_data, out_channel, out_sop, out_eop};
        n_tests++;
        assert (sb.size() > 0) else begin
          n_fail++;
          $error("FAIL sb_unexpected: observed beat 0x%0h expected none", mon_got);
        end
        if (sb.size() > 0) begin
          mon_exp = sb.pop_front();
          check("out_beat", 32'(mon_got), 32'(mon_exp));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int drops;
    int n;
    reset_reset_n = 1'b0;
    enable        = 1'b0;
    cmd_ready     = 1'b1;
    out_ready     = 1'b1;
    err_clear     = 1'b0;
    clear_model();
    cyc(3);
    check("reset_outputs",
          32'({cmd_valid, cmd_sop, cmd_eop, cmd_channel, out_valid, out_sop, out_eop,
               out_channel, busy, err_overrun, err_missed_tick, err_resp}), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    reset_reset_n = 1'b1;
    cyc(2);

    // 1: basic frame, averages of 100..103 on channels 1..4
    off = 0; lat = 1; clear_model();
    for (int c = 1; c <= 4; c++) push_beat(c, c == 1, c == 4);
    enable = 1'b1;
    wait_cond(0, SDIV + 10, "t1_start");
    enable = 1'b0;
    wait_cond(1, 200, "t1_end");
    cyc(3);
    check("t1_sb_drained", 32'(sb.size()), 32'd0);
    check("t1_errs", 32'({err_overrun, err_missed_tick, err_resp}), 32'd0);
    check("t1_out_idle", 32'(out_valid), 32'd0);

    // 2: command backpressure holds cmd_valid/channel
    off = 10; clear_model(); cmd_ready = 1'b0;
    for (int c = 1; c <= 4; c++) push_beat(c, c == 1, c == 4);
    enable = 1'b1;
    wait_cond(2, SDIV + 10, "t2_cmd_valid");
    for (int i = 0; i < 10; i++) begin
      check("t2_cmd_hold", 32'({cmd_valid, cmd_sop, cmd_eop, cmd_channel}), 32'({3'b111, 5'd1}));
      cyc(1);
    end
    cmd_ready = 1'b1;
    enable    = 1'b0;
    wait_cond(1, 300, "t2_end");
    cyc(3);
    check("t2_sb_drained", 32'(sb.size()), 32'd0);

    // 3: output stalled for the whole frame
    off = 3; clear_model(); out_ready = 1'b0;
    push_beat(1, 1'b1, 1'b0);
    enable = 1'b1;
    wait_cond(0, SDIV + 10, "t3_start");
    enable = 1'b0;
    wait_cond(1, 300, "t3_end");
    cyc(2);
    check("t3_held_valid", 32'(out_valid), 32'd1);
    check("t3_held_data", 32'(out_data), 32'(exp_avg(1)));
    check("t3_overrun", 32'(err_overrun), 32'd1);
    out_ready = 1'b1;
    cyc(2);
    check("t3_drained", 32'({out_valid, 1'b0}) | 32'(sb.size()), 32'd0);
    pulse_err_clear();
    check("t3_overrun_clr", 32'(err_overrun), 32'd0);

    // 4: slow ADC, frame longer than the tick period
    off = 5; lat = 20; clear_model();
    for (int c = 1; c <= 4; c++) push_beat(c, c == 1, c == 4);
    enable = 1'b1;
    wait_cond(0, SDIV + 10, "t4_start");
    drops = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1);
      if (!busy) drops++;
    end
    check("t4_no_restart", 32'(drops), 32'd0);
    check("t4_missed_tick", 32'(err_missed_tick), 32'd1);
    enable = 1'b0;
    wait_cond(1, 2000, "t4_end");
    cyc(3);
    check("t4_sb_drained", 32'(sb.size()), 32'd0);
    pulse_err_clear();
    check("t4_missed_clr", 32'(err_missed_tick), 32'd0);

    // 5: wrong channel then silence on ch2 -> timeout, ch2 skipped
    off = 0; lat = 1; clear_model(); bad_ch2 = 1'b1;
    push_beat(1, 1'b1, 1'b0);
    push_beat(3, 1'b0, 1'b0);
    push_beat(4, 1'b0, 1'b1);
    enable = 1'b1;
    wait_cond(3, SDIV + 40, "t5_ch2_cmd");
    enable = 1'b0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      n++;
      if (n == 5) check("t5_mismatch_flag", 32'(err_resp), 32'd1);
      if (cmd_valid && cmd_channel == 5'd3) break;
    end
    check("t5_timeout_cycles", 32'(n), 32'd256);
    wait_cond(1, 200, "t5_end");
    cyc(3);
    check("t5_sb_drained", 32'(sb.size()), 32'd0);
    bad_ch2 = 1'b0;
    pulse_err_clear();
    check("t5_resp_clr", 32'(err_resp), 32'd0);

    // 6: async reset while waiting for a response
    lat = 20; clear_model();
    enable = 1'b1;
    wait_cond(0, SDIV + 10, "t6_start");
    cyc(3);
    check("t6_in_wait", 32'({busy, cmd_valid}), 32'({1'b1, 1'b0}));
    #2;
    reset_reset_n = 1'b0;
    #1;
    check("t6_async_reset",
          32'({cmd_valid, cmd_channel, out_valid, out_sop, out_eop, out_channel, busy,
               err_overrun, err_missed_tick, err_resp}), 32'd0);
    cyc(2);
    reset_reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < SDIV + 20; i++) begin
      cyc(1);
      n++;
      if (cmd_valid) break;
    end
    check("t6_first_cmd_delay", 32'(n), 32'(SDIV));
    check("t6_no_err", 32'({err_overrun, err_missed_tick, err_resp}), 32'd0);
    enable        = 1'b0;
    reset_reset_n = 1'b0;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
